// File: rtl/usb_led_ctrl_if.sv
// Signal bundle between the SoC top and the status-LED / wake-window controller.
// The controller takes the slave modport; the SoC top (or a bench) drives the master side.
interface usb_led_ctrl_if;
   logic       sleep_i;
   logic       pu_i;
   logic       act_i;
   logic [1:0] mode_i;
   logic       led_o;
   logic       awake_o;

   modport master (
      output sleep_i, pu_i, act_i, mode_i,
      input  led_o, awake_o
   );

   modport slave (
      input  sleep_i, pu_i, act_i, mode_i,
      output led_o, awake_o
   );
endinterface

// File: rtl/usb_led_ctrl.sv
// Status-LED and wake-window controller: uptime counter with sleep-gated reload,
// activity stretcher, heartbeat divider and a mode-selected registered LED drive.
module usb_led_ctrl #(
   parameter int unsigned CNT_W       = 21,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned ACT_W       = 16,
   parameter int unsigned HB_W        = 22
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   usb_led_ctrl_if.slave bus
);

   // 7 * 2^(CNT_W-4): the three bits just below the MSB set, MSB clear.
   localparam logic [CNT_W-1:0] RELOAD = {1'b0, 3'b111, {(CNT_W-4){1'b0}}};

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [ACT_W-1:0]       act_cnt_q, act_cnt_d;
   logic [HB_W-1:0]        hb_q, hb_d;
   logic [1:0]             mode_q;
   logic                   led_q, led_d;
   logic                   slp;
   logic                   act;

   generate
      if (SYNC_STAGES == 1) begin : g_sync1
         assign sync_d = bus.sleep_i;
      end else begin : g_syncn
         assign sync_d = {bus.sleep_i, sync_q[SYNC_STAGES-1:1]};
      end
   endgenerate

   assign slp = sync_q[0];
   assign act = (act_cnt_q != '0);

   always_comb begin
      cnt_d = cnt_q;
      if (!cnt_q[CNT_W-1]) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!slp) begin
         cnt_d = RELOAD;
      end
   end

   // A new pulse always restarts the stretch, even mid-countdown.
   always_comb begin
      act_cnt_d = act_cnt_q;
      if (bus.act_i) begin
         act_cnt_d = '1;
      end else if (act) begin
         act_cnt_d = act_cnt_q - 1'b1;
      end
   end

   assign hb_d = hb_q + 1'b1;

   always_comb begin
      led_d = 1'b0;
      case (mode_q)
         2'd0:    led_d = ~bus.pu_i | ~cnt_q[CNT_W-1];
         2'd1:    led_d = ~bus.pu_i | act;
         2'd2:    led_d = bus.pu_i ? hb_q[HB_W-1] : 1'b1;
         default: led_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync_q    <= '0;
         cnt_q     <= '0;
         act_cnt_q <= '0;
         hb_q      <= '0;
         mode_q    <= '0;
         led_q     <= 1'b1;
      end else begin
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         act_cnt_q <= act_cnt_d;
         hb_q      <= hb_d;
         mode_q    <= bus.mode_i;
         led_q     <= led_d;
      end
   end

   assign bus.led_o   = led_q;
   assign bus.awake_o = ~cnt_q[CNT_W-1];

endmodule

// File: tb/tb_usb_led_ctrl.sv
// Directed bench for usb_led_ctrl with CNT_W=6, SYNC_STAGES=2, ACT_W=3, HB_W=4 (RELOAD=28).
module tb_usb_led_ctrl;

   logic clk;
   logic rstn;
   int   total;
   int   bad;

   usb_led_ctrl_if u_if ();

   usb_led_ctrl #(
      .CNT_W       (6),
      .SYNC_STAGES (2),
      .ACT_W       (3),
      .HB_W        (4)
   ) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Awake pattern after k edges since reset release with slp=0:
   // counts 0..31 awake, edge 32 hits the MSB, then 28,29,30,31,32 repeats.
   function automatic logic aw_exp(input int k);
      if (k < 32) return 1'b1;
      return ((k - 32) % 5) != 0;
   endfunction

   task automatic do_reset(input string tag);
      @(negedge clk);
      rstn = 1'b0;
      step();
      step();
      chk({tag, "_rst_led"}, u_if.led_o, 1'b1);
      chk({tag, "_rst_awake"}, u_if.awake_o, 1'b1);
      rstn = 1'b1;
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      rstn         = 1'b1;
      u_if.sleep_i = 1'b0;
      u_if.pu_i    = 1'b1;
      u_if.act_i   = 1'b0;
      u_if.mode_i  = 2'd0;

      // 1: legacy mode, awake
      do_reset("s1");
      for (int k = 1; k <= 45; k++) begin
         step();
         chk($sformatf("s1_awake_k%0d", k), u_if.awake_o, aw_exp(k));
         chk($sformatf("s1_led_k%0d", k), u_if.led_o, aw_exp(k - 1));
      end

      // 2: sleep held from before the first MSB hit
      u_if.sleep_i = 1'b1;
      do_reset("s2");
      for (int k = 1; k <= 40; k++) begin
         step();
         chk($sformatf("s2_awake_k%0d", k), u_if.awake_o, logic'(k < 32));
         chk($sformatf("s2_led_k%0d", k), u_if.led_o, logic'(k <= 32));
      end
      u_if.sleep_i = 1'b0;
      step();
      chk("s2_awake_k41", u_if.awake_o, 1'b0);
      step();
      chk("s2_awake_k42", u_if.awake_o, 1'b0);
      step();
      chk("s2_awake_k43", u_if.awake_o, 1'b1);
      chk("s2_led_k43", u_if.led_o, 1'b0);
      step();
      chk("s2_led_k44", u_if.led_o, 1'b1);
      step();
      step();
      chk("s2_awake_k46", u_if.awake_o, 1'b1);
      step();
      chk("s2_awake_k47", u_if.awake_o, 1'b0);

      // 3: activity mode, single pulse then retriggered pulse
      u_if.mode_i = 2'd1;
      step();
      step();
      chk("s3_idle_led", u_if.led_o, 1'b0);
      u_if.act_i = 1'b1;
      step();
      u_if.act_i = 1'b0;
      chk("s3_a_edge1", u_if.led_o, 1'b0);
      for (int i = 1; i <= 9; i++) begin
         step();
         chk($sformatf("s3_a_i%0d", i), u_if.led_o, logic'(i <= 7));
      end
      u_if.act_i = 1'b1;
      step();
      u_if.act_i = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         step();
         chk($sformatf("s3_b_i%0d", i), u_if.led_o, 1'b1);
      end
      u_if.act_i = 1'b1;
      step();
      u_if.act_i = 1'b0;
      chk("s3_b_i3", u_if.led_o, 1'b1);
      for (int i = 4; i <= 11; i++) begin
         step();
         chk($sformatf("s3_b_i%0d", i), u_if.led_o, logic'(i <= 10));
      end

      // 4: heartbeat, pull-up off, then mode off
      u_if.mode_i = 2'd2;
      do_reset("s4");
      step();
      chk("s4_hb_k1", u_if.led_o, 1'b1);
      for (int k = 2; k <= 33; k++) begin
         step();
         chk($sformatf("s4_hb_k%0d", k), u_if.led_o, logic'(((k - 1) % 16) >= 8));
      end
      u_if.pu_i = 1'b0;
      step();
      chk("s4_pu0_k34", u_if.led_o, 1'b1);
      u_if.mode_i = 2'd3;
      step();
      chk("s4_off_k35", u_if.led_o, 1'b1);
      step();
      chk("s4_off_k36", u_if.led_o, 1'b0);
      u_if.pu_i = 1'b1;
      step();
      chk("s4_off_k37", u_if.led_o, 1'b0);
      step();
      chk("s4_off_k38", u_if.led_o, 1'b0);

      // 5: asynchronous reset with cnt=30, act_cnt=5
      u_if.mode_i = 2'd3;
      do_reset("s5");
      for (int k = 1; k <= 30; k++) begin
         if (k == 28) u_if.act_i = 1'b1;
         step();
         if (k == 28) u_if.act_i = 1'b0;
         chk($sformatf("s5_awake_k%0d", k), u_if.awake_o, 1'b1);
         chk($sformatf("s5_led_k%0d", k), u_if.led_o, logic'(k == 1));
      end
      #2;
      rstn = 1'b0;
      #1;
      chk("s5_async_led", u_if.led_o, 1'b1);
      chk("s5_async_awake", u_if.awake_o, 1'b1);
      u_if.mode_i = 2'd0;
      step();
      rstn = 1'b1;
      for (int k = 1; k <= 38; k++) begin
         step();
         chk($sformatf("s5_re_awake_k%0d", k), u_if.awake_o, aw_exp(k));
         chk($sformatf("s5_re_led_k%0d", k), u_if.led_o, aw_exp(k - 1));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
